butterfly_fx_stream: RTL and testbench



---
 rtl/bfly_pkg.sv | 40 ++++
 rtl/butterfly_fx_stream_if.sv | 37 +++
 rtl/cplx_mul_fx.sv | 70 +++++++
 rtl/butterfly_fx_stream.sv | 167 ++++++++++++++++
 tb/tb_butterfly_fx_stream.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bfly_pkg.sv
// ============================================================================
// Module      : bfly_pkg
// Description : Shared types, mode constants and the rounding helper for the
//               streaming fixed-point butterfly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bfly_pkg;

    typedef enum logic [2:0] {
        S_RECV = 3'd0,
        S_MUL  = 3'd1,
        S_CMB  = 3'd2,
        S_ADD  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam logic MODE_DIT = 1'b0;
    localparam logic MODE_DIF = 1'b1;

    // Wide enough for the full combined product at the largest DW (32).
    localparam int RS_W = 66;

    // Round half toward +inf, then arithmetic shift right by frac.
    function automatic logic signed [RS_W-1:0] round_shift(
        input logic signed [RS_W-1:0] value,
        input int                     frac
    );
        logic signed [RS_W-1:0] v;
        v = value;
        if (frac > 0) begin
            v = v + (66'sd1 <<< (frac - 1));
        end
        return v >>> frac;
    endfunction

endpackage

`default_nettype wire

// File: rtl/butterfly_fx_stream_if.sv
// ============================================================================
// Module      : butterfly_fx_stream_if
// Description : Byte-intake and result handshake bundle of the butterfly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface butterfly_fx_stream_if #(
    parameter int DW = 16
);
    localparam int OW = DW + 2;

    logic [7:0]           i_data;
    logic                 i_enb;
    logic                 o_ready;
    logic                 i_mode;
    logic                 o_valid;
    logic                 i_ready;
    logic signed [OW-1:0] o_A_re;
    logic signed [OW-1:0] o_A_im;
    logic signed [OW-1:0] o_B_re;
    logic signed [OW-1:0] o_B_im;
    logic                 o_mode;

    modport slave (
        input  i_data, i_enb, i_mode, i_ready,
        output o_ready, o_valid, o_A_re, o_A_im, o_B_re, o_B_im, o_mode
    );

    modport master (
        output i_data, i_enb, i_mode, i_ready,
        input  o_ready, o_valid, o_A_re, o_A_im, o_B_re, o_B_im, o_mode
    );

endinterface

`default_nettype wire

// File: rtl/cplx_mul_fx.sv
// ============================================================================
// Module      : cplx_mul_fx
// Description : Two-stage registered complex multiply a*b with Q1.FRAC
//               rounding; a is DW+1 bits wide, b is DW bits wide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cplx_mul_fx
    import bfly_pkg::*;
#(
    parameter int DW   = 16,
    parameter int FRAC = DW - 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en_mul,
    input  logic                 i_en_cmb,
    input  logic signed [DW:0]   i_a_re,
    input  logic signed [DW:0]   i_a_im,
    input  logic signed [DW-1:0] i_b_re,
    input  logic signed [DW-1:0] i_b_im,
    output logic signed [DW+1:0] o_p_re,
    output logic signed [DW+1:0] o_p_im
);
    localparam int PW = 2 * DW + 1;
    localparam int SW = PW + 1;
    localparam int OW = DW + 2;

    logic signed [PW-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic signed [SW-1:0] w_t_re, w_t_im;
    logic signed [OW-1:0] r_t_re, r_t_im;

    assign w_a_re = PW'(i_a_re);
    assign w_a_im = PW'(i_a_im);
    assign w_b_re = PW'(i_b_re);
    assign w_b_im = PW'(i_b_im);

    assign w_t_re = SW'(r_p_rr) - SW'(r_p_ii);
    assign w_t_im = SW'(r_p_ri) + SW'(r_p_ir);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p_rr <= '0;
            r_p_ii <= '0;
            r_p_ri <= '0;
            r_p_ir <= '0;
            r_t_re <= '0;
            r_t_im <= '0;
        end else begin
            if (i_en_mul) begin
                r_p_rr <= w_a_re * w_b_re;
                r_p_ii <= w_a_im * w_b_im;
                r_p_ri <= w_a_re * w_b_im;
                r_p_ir <= w_a_im * w_b_re;
            end
            if (i_en_cmb) begin
                r_t_re <= OW'(round_shift(RS_W'(w_t_re), FRAC));
                r_t_im <= OW'(round_shift(RS_W'(w_t_im), FRAC));
            end
        end
    end

    assign o_p_re = r_t_re;
    assign o_p_im = r_t_im;

endmodule

`default_nettype wire

// File: rtl/butterfly_fx_stream.sv
// ============================================================================
// Module      : butterfly_fx_stream
// Description : Byte-serial radix-2 DIT/DIF fixed-point butterfly with a
//               ready/valid result port. Optional macro BFLY_SCALE_EN halves
//               every result (round half up) before the output registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module butterfly_fx_stream
    import bfly_pkg::*;
#(
    parameter int DW   = 16,
    parameter int FRAC = DW - 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    butterfly_fx_stream_if.slave bus
);
    localparam int OW  = DW + 2;
    localparam int AW  = DW + 1;
    localparam int NB  = 6 * DW / 8;
    localparam int CW  = $clog2(NB);
    localparam int OPW = 6 * DW;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [OPW-1:0]       r_opnd;
    logic                 r_mode;
    logic                 r_valid;
    logic                 r_omode;
    logic signed [OW-1:0] r_a_re, r_a_im, r_b_re, r_b_im;

    logic signed [DW-1:0] w_x_re, w_x_im, w_y_re, w_y_im, w_w_re, w_w_im;
    logic signed [AW-1:0] w_m_re, w_m_im;
    logic signed [OW-1:0] w_p_re, w_p_im, w_t_re, w_t_im;
    logic signed [OW-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [OW-1:0] w_a_re_o, w_a_im_o, w_b_re_o, w_b_im_o;
    logic                 w_en_mul, w_en_cmb, w_accept;

    // Operand words arrive first-word-first, so x sits at the top of the shifter.
    assign w_x_re = r_opnd[OPW-1      -: DW];
    assign w_x_im = r_opnd[OPW-DW-1   -: DW];
    assign w_y_re = r_opnd[OPW-2*DW-1 -: DW];
    assign w_y_im = r_opnd[OPW-3*DW-1 -: DW];
    assign w_w_re = r_opnd[OPW-4*DW-1 -: DW];
    assign w_w_im = r_opnd[DW-1:0];

    assign w_m_re = (r_mode == MODE_DIF) ? AW'(w_x_re) - AW'(w_y_re) : AW'(w_y_re);
    assign w_m_im = (r_mode == MODE_DIF) ? AW'(w_x_im) - AW'(w_y_im) : AW'(w_y_im);

    assign w_en_mul = (r_state == S_MUL);
    assign w_en_cmb = (r_state == S_CMB);
    assign w_accept = bus.i_enb && (r_state == S_RECV);

    cplx_mul_fx #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_mul (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en_mul (w_en_mul),
        .i_en_cmb (w_en_cmb),
        .i_a_re   (w_m_re),
        .i_a_im   (w_m_im),
        .i_b_re   (w_w_re),
        .i_b_im   (w_w_im),
        .o_p_re   (w_p_re),
        .o_p_im   (w_p_im)
    );

    // The DIT twiddle product keeps only DW+1 bits before the add/sub.
    assign w_t_re = OW'($signed(w_p_re[DW:0]));
    assign w_t_im = OW'($signed(w_p_im[DW:0]));

    always_comb begin
        w_a_re = OW'(w_x_re) + w_t_re;
        w_a_im = OW'(w_x_im) + w_t_im;
        w_b_re = OW'(w_x_re) - w_t_re;
        w_b_im = OW'(w_x_im) - w_t_im;
        if (r_mode == MODE_DIF) begin
            w_a_re = OW'(w_x_re) + OW'(w_y_re);
            w_a_im = OW'(w_x_im) + OW'(w_y_im);
            w_b_re = w_p_re;
            w_b_im = w_p_im;
        end
    end

`ifdef BFLY_SCALE_EN
    function automatic logic signed [OW-1:0] half_up(input logic signed [OW-1:0] v);
        logic signed [OW:0] s;
        s = (OW+1)'(v) + (OW+1)'(1);
        return OW'(s >>> 1);
    endfunction

    assign w_a_re_o = half_up(w_a_re);
    assign w_a_im_o = half_up(w_a_im);
    assign w_b_re_o = half_up(w_b_re);
    assign w_b_im_o = half_up(w_b_im);
`else
    assign w_a_re_o = w_a_re;
    assign w_a_im_o = w_a_im;
    assign w_b_re_o = w_b_re;
    assign w_b_im_o = w_b_im;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_RECV;
            r_cnt   <= '0;
            r_opnd  <= '0;
            r_mode  <= MODE_DIT;
            r_valid <= 1'b0;
            r_omode <= 1'b0;
            r_a_re  <= '0;
            r_a_im  <= '0;
            r_b_re  <= '0;
            r_b_im  <= '0;
        end else begin
            case (r_state)
                S_RECV: begin
                    if (w_accept) begin
                        r_opnd <= {r_opnd[OPW-9:0], bus.i_data};
                        if (r_cnt == '0) begin
                            r_mode <= bus.i_mode;
                        end
                        if (r_cnt == CW'(NB - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_MUL;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_MUL: r_state <= S_CMB;
                S_CMB: r_state <= S_ADD;
                S_ADD: begin
                    r_a_re  <= w_a_re_o;
                    r_a_im  <= w_a_im_o;
                    r_b_re  <= w_b_re_o;
                    r_b_im  <= w_b_im_o;
                    r_omode <= r_mode;
                    r_valid <= 1'b1;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (bus.i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_RECV;
                    end
                end
                default: r_state <= S_RECV;
            endcase
        end
    end

    assign bus.o_ready = (r_state == S_RECV);
    assign bus.o_valid = r_valid;
    assign bus.o_mode  = r_omode;
    assign bus.o_A_re  = r_a_re;
    assign bus.o_A_im  = r_a_im;
    assign bus.o_B_re  = r_b_re;
    assign bus.o_B_im  = r_b_im;

endmodule

`default_nettype wire

// File: tb/tb_butterfly_fx_stream.sv
// ============================================================================
// Module      : tb_butterfly_fx_stream
// Description : Self-checking bench for butterfly_fx_stream (DW=16, FRAC=15);
//               honours BFLY_SCALE_EN when the build defines it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_butterfly_fx_stream;
    import bfly_pkg::*;

    localparam int DW   = 16;
    localparam int FRAC = 15;
    localparam int OW   = DW + 2;
    localparam int NB   = 6 * DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    butterfly_fx_stream_if #(.DW(DW)) bus();

    butterfly_fx_stream #(
        .DW   (DW),
        .FRAC (FRAC)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        longint ar, ai, br, bi;
        logic   m;
    } res_t;

    res_t exp_q[$];
    int   total  = 0;
    int   bad    = 0;
    int   n_sent = 0;
    int   n_recv = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint wrapn(input longint v, input int n);
        longint m, r;
        m = longint'(1) << n;
        r = v & (m - 1);
        if (r >= (m >> 1)) r = r - m;
        return r;
    endfunction

    function automatic longint rnd(input longint v);
        return (v + (longint'(1) << (FRAC - 1))) >>> FRAC;
    endfunction

    function automatic longint scl(input longint v);
`ifdef BFLY_SCALE_EN
        return (v + 1) >>> 1;
`else
        return v;
`endif
    endfunction

    function automatic res_t model(input longint xr, xi, yr, yi, wr, wi, input logic m);
        res_t   r;
        longint tr, ti, dr, di;
        if (m == MODE_DIT) begin
            tr   = wrapn(rnd(yr * wr - yi * wi), DW + 1);
            ti   = wrapn(rnd(yr * wi + yi * wr), DW + 1);
            r.ar = xr + tr;  r.ai = xi + ti;
            r.br = xr - tr;  r.bi = xi - ti;
        end else begin
            dr   = xr - yr;  di = xi - yi;
            r.ar = xr + yr;  r.ai = xi + yi;
            r.br = wrapn(rnd(dr * wr - di * wi), OW);
            r.bi = wrapn(rnd(dr * wi + di * wr), OW);
        end
        r.ar = scl(wrapn(r.ar, OW));  r.ai = scl(wrapn(r.ai, OW));
        r.br = scl(wrapn(r.br, OW));  r.bi = scl(wrapn(r.bi, OW));
        r.m  = m;
        return r;
    endfunction

    // ---------------- compare process ----------------
    logic prev_valid = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && bus.i_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_recv++;
            end
            if (bus.o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    check("A_re", longint'(bus.o_A_re), exp_q[0].ar);
                    check("A_im", longint'(bus.o_A_im), exp_q[0].ai);
                    check("B_re", longint'(bus.o_B_re), exp_q[0].br);
                    check("B_im", longint'(bus.o_B_im), exp_q[0].bi);
                    check("mode", longint'(bus.o_mode), longint'(exp_q[0].m));
                end
            end
            prev_valid = bus.o_valid;
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic put_byte(input logic [7:0] b, input logic m, input int gap);
        int g;
        for (int k = 0; k < gap; k++) begin
            bus.i_enb = 1'b0;
            @(negedge clk);
        end
        bus.i_data = b;
        bus.i_mode = m;
        bus.i_enb  = 1'b1;
        g = 0;
        while (!bus.o_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("byte_accept_timeout", 0, 1);
        @(negedge clk);
        bus.i_enb = 1'b0;
    endtask

    task automatic send_job(input longint xr, xi, yr, yi, wr, wi,
                            input logic m, input int maxgap, input int nbytes);
        longint      wd[6];
        logic [15:0] wv;
        int          cnt;
        wd = '{xr, xi, yr, yi, wr, wi};
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            wv = wd[i][15:0];
            if (cnt < nbytes) put_byte(wv[15:8], m, $urandom_range(0, maxgap));
            cnt++;
            if (cnt < nbytes) put_byte(wv[7:0], m, $urandom_range(0, maxgap));
            cnt++;
        end
        if (nbytes >= NB) begin
            exp_q.push_back(model(xr, xi, yr, yi, wr, wi, m));
            n_sent++;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 0, 1);
    endtask

    function automatic longint r16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return longint'(t);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        res_t r;
        int   lat;
        bus.i_data  = '0;
        bus.i_enb   = 1'b0;
        bus.i_mode  = 1'b0;
        bus.i_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_valid", longint'(bus.o_valid), 0);
        check("rst_A_re", longint'(bus.o_A_re), 0);
        check("rst_B_im", longint'(bus.o_B_im), 0);
        check("rst_mode", longint'(bus.o_mode), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", longint'(bus.o_ready), 1);

        // Model pinned to hand-computed values.
        r = model(1000, -2000, 4000, 0, 16384, 0, MODE_DIT);
`ifdef BFLY_SCALE_EN
        check("pin_dit_A_re", r.ar, 1500);   check("pin_dit_A_im", r.ai, -1000);
        check("pin_dit_B_re", r.br, -500);   check("pin_dit_B_im", r.bi, -1000);
`else
        check("pin_dit_A_re", r.ar, 3000);   check("pin_dit_A_im", r.ai, -2000);
        check("pin_dit_B_re", r.br, -1000);  check("pin_dit_B_im", r.bi, -2000);
`endif
        r = model(1000, -2000, 4000, 0, 16384, 0, MODE_DIF);
`ifdef BFLY_SCALE_EN
        check("pin_dif_A_re", r.ar, 2500);   check("pin_dif_A_im", r.ai, -1000);
        check("pin_dif_B_re", r.br, -750);   check("pin_dif_B_im", r.bi, -500);
`else
        check("pin_dif_A_re", r.ar, 5000);   check("pin_dif_A_im", r.ai, -2000);
        check("pin_dif_B_re", r.br, -1500);  check("pin_dif_B_im", r.bi, -1000);
`endif
        r = model(0, 0, 1, 0, 16384, 0, MODE_DIT);
        check("pin_round_up", r.br, scl(-1));
        r = model(0, 0, -1, 0, 16384, 0, MODE_DIT);
        check("pin_round_neg", r.br, 0);
        r = model(0, 0, 0, 32767, 0, 32767, MODE_DIT);
`ifdef BFLY_SCALE_EN
        check("pin_cplx_t_re", r.ar, -16383);
`else
        check("pin_cplx_t_re", r.ar, -32766);
`endif

        // 1. DIT with latency and single-cycle valid.
        send_job(1000, -2000, 4000, 0, 16384, 0, MODE_DIT, 0, NB);
        lat = 0;
        while (!bus.o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 3);
        @(negedge clk);
        check("valid_pulse", longint'(bus.o_valid), 0);
        wait_drain();

        // 2. DIF on the same operands.
        send_job(1000, -2000, 4000, 0, 16384, 0, MODE_DIF, 0, NB);
        wait_drain();

        // 3. Rounding boundaries.
        send_job(0, 0, 1, 0, 16384, 0, MODE_DIT, 0, NB);
        send_job(0, 0, -1, 0, 16384, 0, MODE_DIT, 0, NB);
        send_job(0, 0, 0, 32767, 0, 32767, MODE_DIT, 0, NB);
        send_job(-32768, 32767, -32768, -32768, -32768, -32768, MODE_DIF, 0, NB);
        wait_drain();

        // 4. Backpressure with ignored bytes.
        bus.i_ready = 1'b0;
        send_job(-1234, 567, 8901, -2345, 23170, -23170, MODE_DIT, 1, NB);
        lat = 0;
        while (!bus.o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        for (int k = 0; k < 10; k++) begin
            bus.i_enb  = 1'b1;
            bus.i_data = 8'($urandom);
            @(negedge clk);
            check("bp_ready_low", longint'(bus.o_ready), 0);
            check("bp_valid_held", longint'(bus.o_valid), 1);
        end
        bus.i_enb   = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", longint'(bus.o_valid), 0);
        check("bp_release_ready", longint'(bus.o_ready), 1);
        send_job(300, -400, -5000, 6000, 12000, 20000, MODE_DIF, 0, NB);
        wait_drain();

        // 5. Asynchronous reset mid-job.
        send_job(111, 222, 333, 444, 555, 666, MODE_DIT, 0, 8);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", longint'(bus.o_valid), 0);
        check("arst_A_re", longint'(bus.o_A_re), 0);
        check("arst_A_im", longint'(bus.o_A_im), 0);
        check("arst_B_re", longint'(bus.o_B_re), 0);
        check("arst_B_im", longint'(bus.o_B_im), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_job(-7000, 3000, 2500, -1500, 16384, 16384, MODE_DIT, 0, NB);
        wait_drain();

        // 6. Random byte gaps over mixed jobs.
        for (int j = 0; j < 20; j++) begin
            send_job(r16(), r16(), r16(), r16(), r16(), r16(),
                     logic'($urandom_range(0, 1)), 2, NB);
        end
        wait_drain();
        check("jobs_received", n_recv, n_sent);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
